// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the codec-control I2C write engine:
//   - state_t        : engine FSM states
//   - N_SLOTS        : bit slots per transaction (3 bytes x (8 data + 1 ACK))
//   - ACK_SLOTS      : slot indices that carry the slave acknowledge
//   - START_Q/STOP_Q : quarter periods spent in START and STOP
//   - calcQ()        : system clocks per quarter SCL period
//   - isAckSlot()    : true when a slot index is an ACK slot
// ---------------------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BIT   = 3'd2,
    ST_STOP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int N_SLOTS = 27;
  localparam int START_Q = 2;
  localparam int STOP_Q  = 4;

  localparam logic [4:0] ACK_SLOTS [0:2] = '{5'd8, 5'd17, 5'd26};

  function automatic int calcQ(input int clkFreq, input int i2cFreq);
    return clkFreq / (4 * i2cFreq);
  endfunction

  function automatic logic isAckSlot(input logic [4:0] slot);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (slot == ACK_SLOTS[i]) hit = 1'b1;
      else                      hit = hit;
    end
    return hit;
  endfunction

endpackage

// File: rtl/i2c_write_engine_if.sv
// ---------------------------------------------------------------------------
// i2c_write_engine_if
// Handshake between the codec configuration sequencer and the I2C write
// engine, plus the push-pull SCL line.
//   iDATA    : 24-bit word {slave addr+R/W, reg addr, data}
//   iGO      : level request from the sequencer
//   oEND     : transaction finished, held until iGO drops
//   oACK     : 1 = at least one NACK in the last transaction
//   oBUSY    : engine busy from accept until back in IDLE
//   I2C_SCLK : SCL
// Modports: master = sequencer side, slave = engine side.
// SDA is open-drain and stays a plain inout port on the engine.
// ---------------------------------------------------------------------------
interface i2c_write_engine_if;

  logic [23:0] iDATA;
  logic        iGO;
  logic        oEND;
  logic        oACK;
  logic        oBUSY;
  logic        I2C_SCLK;

  modport master (
    output iDATA,
    output iGO,
    input  oEND,
    input  oACK,
    input  oBUSY,
    input  I2C_SCLK
  );

  modport slave (
    input  iDATA,
    input  iGO,
    output oEND,
    output oACK,
    output oBUSY,
    output I2C_SCLK
  );

endinterface

// File: rtl/i2c_tick_gen.sv
// ---------------------------------------------------------------------------
// i2c_tick_gen
// Quarter-SCL-period strobe. The counter runs 0..Q-1 while enabled and wraps;
// oTICK is high on the last clock of each quarter so the engine advances on
// exactly every Q-th edge after the clear.
//   iCLK   : system clock
//   iRST_N : synchronous active-low reset (counter to 0)
//   iCLR   : synchronous clear, asserted on the accepting edge
//   iEN    : count enable (engine busy)
//   oTICK  : end-of-quarter strobe
// ---------------------------------------------------------------------------
module i2c_tick_gen #(
  parameter int Q = 625
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic iCLR,
  input  logic iEN,
  output logic oTICK
);

  localparam int CW = (Q > 1) ? $clog2(Q) : 1;
  localparam logic [CW-1:0] LAST = CW'(Q - 1);

  logic [CW-1:0] cnt_r;

  // Quarter counter with clear and wrap at Q-1.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      cnt_r <= '0;
    end else if (iCLR) begin
      cnt_r <= '0;
    end else if (iEN) begin
      if (cnt_r == LAST) cnt_r <= '0;
      else               cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign oTICK = iEN && (cnt_r == LAST);

endmodule

// File: rtl/i2c_write_engine.sv
// ---------------------------------------------------------------------------
// i2c_write_engine
// Single-clock I2C master that sends one 24-bit write (slave addr, register
// addr, data) per request. All three bytes are always sent; any missing ACK
// is reported through oACK once the transaction ends.
// Ports:
//   iCLK     : system clock (only clock)
//   iRST_N   : synchronous active-low reset; abandons the bus without STOP
//   bus      : sequencer handshake + SCL (slave modport)
//   I2C_SDAT : SDA, open-drain (drives 0 or Z)
// Timing: START 2 quarters, 27 slots x 4 quarters, STOP 4 quarters; oEND
// rises 114*Q clocks after the accepting edge.
// ---------------------------------------------------------------------------
module i2c_write_engine #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int I2C_FREQ = 20_000
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  i2c_write_engine_if.slave    bus,
  inout  wire                  I2C_SDAT
);

  import i2c_pkg::*;

  localparam int Q = calcQ(CLK_FREQ, I2C_FREQ);

  state_t      state_r;
  logic [23:0] shift_r;
  logic [4:0]  slot_r;
  logic [1:0]  qtr_r;
  logic        nack_r;
  logic        scl_r;
  logic        sdaLow_r;
  logic        end_r;
  logic        ack_r;
  logic        busy_r;

  logic        tick_s;
  logic        accept_s;
  logic        sdaIn_s;
  logic [23:0] shiftNext_s;

  assign I2C_SDAT = sdaLow_r ? 1'b0 : 1'bz;
  assign sdaIn_s  = I2C_SDAT;

  assign bus.I2C_SCLK = scl_r;
  assign bus.oEND     = end_r;
  assign bus.oACK     = ack_r;
  assign bus.oBUSY    = busy_r;

  // Accept strobe and the shift-register value after the current slot
  // (data slots consume one bit, ACK slots leave the register alone).
  always_comb begin
    accept_s    = 1'b0;
    shiftNext_s = shift_r;
    if (state_r == ST_IDLE) accept_s = bus.iGO;
    else                    accept_s = 1'b0;
    if (isAckSlot(slot_r)) shiftNext_s = shift_r;
    else                   shiftNext_s = {shift_r[22:0], 1'b0};
  end

  i2c_tick_gen #(.Q(Q)) uTick (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .iCLR   (accept_s),
    .iEN    (busy_r),
    .oTICK  (tick_s)
  );

  // Transaction FSM; advances one quarter per tick, outputs are registered
  // so each quarter's SCL/SDA levels appear on the tick edge itself.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_r  <= ST_IDLE;
      shift_r  <= 24'h000000;
      slot_r   <= 5'd0;
      qtr_r    <= 2'd0;
      nack_r   <= 1'b0;
      scl_r    <= 1'b1;
      sdaLow_r <= 1'b0;
      end_r    <= 1'b0;
      ack_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.iGO) begin
            shift_r  <= bus.iDATA;
            nack_r   <= 1'b0;
            ack_r    <= 1'b0;
            busy_r   <= 1'b1;
            slot_r   <= 5'd0;
            qtr_r    <= 2'd0;
            scl_r    <= 1'b1;
            sdaLow_r <= 1'b1;          // START: SDA falls with SCL high
            state_r  <= ST_START;
          end
        end

        ST_START: begin
          if (tick_s) begin
            if (qtr_r == 2'(START_Q - 1)) begin
              state_r  <= ST_BIT;
              qtr_r    <= 2'd0;
              slot_r   <= 5'd0;
              sdaLow_r <= ~shift_r[23];
            end else begin
              qtr_r    <= qtr_r + 2'd1;
            end
            scl_r <= 1'b0;
          end
        end

        ST_BIT: begin
          if (tick_s) begin
            case (qtr_r)
              2'd0: qtr_r <= 2'd1;
              2'd1: begin
                qtr_r <= 2'd2;
                scl_r <= 1'b1;
              end
              2'd2: begin
                qtr_r <= 2'd3;
                // Only a clean 0 counts as ACK; Z or X both flag a NACK.
                if (isAckSlot(slot_r)) begin
                  if (sdaIn_s == 1'b0) nack_r <= nack_r;
                  else                 nack_r <= 1'b1;
                end
              end
              2'd3: begin
                qtr_r   <= 2'd0;
                scl_r   <= 1'b0;
                shift_r <= shiftNext_s;
                if (slot_r == 5'(N_SLOTS - 1)) begin
                  state_r  <= ST_STOP;
                  sdaLow_r <= 1'b1;
                end else begin
                  slot_r   <= slot_r + 5'd1;
                  sdaLow_r <= isAckSlot(slot_r + 5'd1) ? 1'b0 : ~shiftNext_s[23];
                end
              end
              default: qtr_r <= 2'd0;
            endcase
          end
        end

        ST_STOP: begin
          if (tick_s) begin
            if (qtr_r == 2'(STOP_Q - 1)) begin
              qtr_r   <= 2'd0;
              state_r <= ST_DONE;
              end_r   <= 1'b1;
              ack_r   <= nack_r;
            end else begin
              qtr_r    <= qtr_r + 2'd1;
              scl_r    <= 1'b1;
              // SDA held low through q1, released (rises) at q2 with SCL high.
              sdaLow_r <= (qtr_r == 2'd0);
            end
          end
        end

        ST_DONE: begin
          if (!bus.iGO) begin
            state_r <= ST_IDLE;
            end_r   <= 1'b0;
            busy_r  <= 1'b0;
          end
        end

        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule
